// File: rtl/predicate_pkg.sv
// Shared predicate-file definitions: write-op encodings and the
// combine function used by both write ports.
package predicate_pkg;

  localparam logic [1:0] PRED_SET = 2'b00;
  localparam logic [1:0] PRED_AND = 2'b01;
  localparam logic [1:0] PRED_OR  = 2'b10;
  localparam logic [1:0] PRED_XOR = 2'b11;

  function automatic logic pred_combine(
    input logic       old_v,
    input logic [1:0] op,
    input logic       d
  );
    logic r;
    r = d;
    unique case (op)
      PRED_SET: r = d;
      PRED_AND: r = old_v & d;
      PRED_OR:  r = old_v | d;
      PRED_XOR: r = old_v ^ d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/predicate_ckpt_buffer.sv
// Circular snapshot buffer: head/tail/count, legality checks, ckpt_err.
// Ports: take/release/restore requests in; next_regs in; restore_vec out.
module predicate_ckpt_buffer
  import predicate_pkg::*;
#(
  parameter int NUM_REG   = 8,
  parameter int CKPT_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ckpt_take,
  input  logic                 ckpt_release,
  input  logic                 ckpt_restore,
  input  logic [CKPT_BITS-1:0] ckpt_restore_id,
  input  logic [NUM_REG-1:0]   next_regs,
  output logic                 ckpt_ready,
  output logic [CKPT_BITS-1:0] ckpt_id,
  output logic [CKPT_BITS:0]   ckpt_count,
  output logic                 ckpt_err,
  output logic                 restore_ok,
  output logic [NUM_REG-1:0]   restore_vec
);

  localparam int DEPTH = 1 << CKPT_BITS;
  localparam logic [CKPT_BITS-1:0] ONE_ID = 1;
  localparam logic [CKPT_BITS:0] ONE_CNT = 1;
  localparam logic [CKPT_BITS:0] FULL_CNT = (CKPT_BITS+1)'(DEPTH);

  logic [CKPT_BITS-1:0] head_q, head_d;
  logic [CKPT_BITS-1:0] tail_q, tail_d;
  logic [CKPT_BITS:0]   count_q, count_d;
  logic                 err_q, err_d;
  logic [NUM_REG-1:0]   slot_q [DEPTH];

  logic [CKPT_BITS-1:0] offs;
  logic live, rel_ok, take_ok, bad, slot_we;

  assign ckpt_ready  = (count_q != FULL_CNT);
  assign ckpt_id     = tail_q;
  assign ckpt_count  = count_q;
  assign ckpt_err    = err_q;
  assign restore_vec = slot_q[ckpt_restore_id];
  assign restore_ok  = ckpt_restore & live;

  always_comb begin
    offs    = ckpt_restore_id - head_q;
    live    = ({1'b0, offs} < count_q);
    rel_ok  = ckpt_release && (count_q != '0);
    take_ok = ckpt_take && (ckpt_ready || rel_ok);
    bad     = 1'b0;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = 1'b0;
    slot_we = 1'b0;
    if (ckpt_restore) begin
      // restore wins; same-cycle take/release are silently dropped
      err_d = !live;
      if (live) begin
        tail_d  = ckpt_restore_id + ONE_ID;
        count_d = {1'b0, offs} + ONE_CNT;
      end
    end else begin
      // any illegal part drops the whole buffer request
      bad   = (ckpt_take && !take_ok) ||
              (ckpt_release && !rel_ok);
      err_d = bad;
      if (!bad) begin
        if (take_ok) begin
          slot_we = 1'b1;
          tail_d  = tail_q + ONE_ID;
        end
        if (rel_ok) head_d = head_q + ONE_ID;
        if (take_ok && !rel_ok) count_d = count_q + ONE_CNT;
        if (rel_ok && !take_ok) count_d = count_q - ONE_CNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (slot_we && !reset) slot_q[tail_q] <= next_regs;
  end

endmodule

// File: rtl/predicate_regfile_ckpt.sv
// Predicate register file: chained combining writes, bypassed reads,
// checkpoint restore. p0 is hardwired true.
module predicate_regfile_ckpt
  import predicate_pkg::*;
#(
  parameter int REG_BITS  = 3,
  parameter int NUM_RD    = 3,
  parameter int CKPT_BITS = 2,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD*REG_BITS-1:0]   rd_addr,
  output logic [NUM_RD-1:0]            rd_data,
  input  logic [1:0]                   wr_en,
  input  logic [2*REG_BITS-1:0]        wr_addr,
  input  logic [3:0]                   wr_op,
  input  logic [1:0]                   wr_data,
  input  logic                         ckpt_take,
  output logic                         ckpt_ready,
  output logic [CKPT_BITS-1:0]         ckpt_id,
  input  logic                         ckpt_release,
  input  logic                         ckpt_restore,
  input  logic [CKPT_BITS-1:0]         ckpt_restore_id,
  output logic [CKPT_BITS:0]           ckpt_count,
  output logic                         ckpt_err
);

  localparam int NUM_REG = 1 << REG_BITS;

  logic [NUM_REG-1:0]  regs_q, regs_d;
  logic [NUM_REG-1:0]  regs_p0, regs_w;
  logic [NUM_REG-1:0]  restore_vec, rd_src;
  logic [REG_BITS-1:0] wa0, wa1;
  logic                restore_ok;

  assign wa0 = wr_addr[REG_BITS-1:0];
  assign wa1 = wr_addr[2*REG_BITS-1:REG_BITS];

  always_comb begin
    regs_p0 = regs_q;
    if (wr_en[0] && wa0 != '0)
      regs_p0[wa0] = pred_combine(regs_q[wa0], wr_op[1:0], wr_data[0]);
    // port 1 sees port 0's result so compare pairs chain
    regs_w = regs_p0;
    if (wr_en[1] && wa1 != '0)
      regs_w[wa1] = pred_combine(regs_p0[wa1], wr_op[3:2], wr_data[1]);
    regs_w[0] = 1'b1;
    // any restore request discards this cycle's writes
    if (ckpt_restore)
      regs_d = restore_ok ? restore_vec : regs_q;
    else
      regs_d = regs_w;
    regs_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= NUM_REG'(1);
    else       regs_q <= regs_d;
  end

  assign rd_src = BYPASS ? regs_d : regs_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign rd_data[k] = rd_src[rd_addr[k*REG_BITS +: REG_BITS]];
  end

  predicate_ckpt_buffer #(
    .NUM_REG   (NUM_REG),
    .CKPT_BITS (CKPT_BITS)
  ) u_ckpt (
    .clk             (clk),
    .reset           (reset),
    .ckpt_take       (ckpt_take),
    .ckpt_release    (ckpt_release),
    .ckpt_restore    (ckpt_restore),
    .ckpt_restore_id (ckpt_restore_id),
    .next_regs       (regs_w),
    .ckpt_ready      (ckpt_ready),
    .ckpt_id         (ckpt_id),
    .ckpt_count      (ckpt_count),
    .ckpt_err        (ckpt_err),
    .restore_ok      (restore_ok),
    .restore_vec     (restore_vec)
  );

endmodule

// File: tb/tb_predicate_regfile_ckpt.sv
// Scoreboard bench for predicate_regfile_ckpt: directed plan plus
// random traffic against a queue-based reference model.
module tb_predicate_regfile_ckpt;

  localparam int RB = 3;
  localparam int NR = 3;
  localparam int CB = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NR*RB-1:0] rd_addr = '0;
  logic [NR-1:0] rd_data;
  logic [1:0]    wr_en = '0;
  logic [2*RB-1:0] wr_addr = '0;
  logic [3:0]    wr_op = '0;
  logic [1:0]    wr_data = '0;
  logic          ckpt_take = 1'b0;
  logic          ckpt_ready;
  logic [CB-1:0] ckpt_id;
  logic          ckpt_release = 1'b0;
  logic          ckpt_restore = 1'b0;
  logic [CB-1:0] ckpt_restore_id = '0;
  logic [CB:0]   ckpt_count;
  logic          ckpt_err;

  predicate_regfile_ckpt #(
    .REG_BITS(RB), .NUM_RD(NR), .CKPT_BITS(CB), .BYPASS(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_op(wr_op), .wr_data(wr_data),
    .ckpt_take(ckpt_take), .ckpt_ready(ckpt_ready),
    .ckpt_id(ckpt_id), .ckpt_release(ckpt_release),
    .ckpt_restore(ckpt_restore),
    .ckpt_restore_id(ckpt_restore_id),
    .ckpt_count(ckpt_count), .ckpt_err(ckpt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic [2:0] a0, a1;
    logic [1:0] op0, op1;
    logic       d0, d1;
    logic       tk, rl, rs;
    logic [1:0] rid;
    logic [2:0] r0, r1, r2;
  } stim_t;

  typedef struct {
    logic [NR-1:0] rd;
    logic          ready;
    logic [CB-1:0] id;
    logic [CB:0]   count;
    logic          err;
  } exp_t;

  typedef struct {
    int         id;
    logic [7:0] bits;
  } snap_t;

  exp_t  exp_q[$];
  snap_t live_q[$];
  logic [7:0] m_regs;
  int    m_tail;
  logic  m_err;
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic logic ref_op(logic o, logic [1:0] op, logic d);
    case (op)
      2'd0: return d;
      2'd1: return o & d;
      2'd2: return o | d;
      default: return o ^ d;
    endcase
  endfunction

  function automatic stim_t idle(int r0 = 0, int r1 = 1, int r2 = 2);
    stim_t s;
    s = '{default: '0};
    s.r0 = 3'(r0);
    s.r1 = 3'(r1);
    s.r2 = 3'(r2);
    return s;
  endfunction

  function automatic stim_t wr1(int a, int op, logic d,
                                int r0 = 0, int r1 = 1, int r2 = 2);
    stim_t s;
    s = idle(r0, r1, r2);
    s.en = 2'b01;
    s.a0 = 3'(a);
    s.op0 = 2'(op);
    s.d0 = d;
    return s;
  endfunction

  task automatic step(input stim_t s);
    logic [7:0] w, nv;
    exp_t e;
    int hit;
    logic rel_ok, take_ok, bad;
    @(posedge clk);
    #1;
    reset = s.rst;
    wr_en = s.en;
    wr_addr = {s.a1, s.a0};
    wr_op = {s.op1, s.op0};
    wr_data = {s.d1, s.d0};
    ckpt_take = s.tk;
    ckpt_release = s.rl;
    ckpt_restore = s.rs;
    ckpt_restore_id = s.rid;
    rd_addr = {s.r2, s.r1, s.r0};
    w = m_regs;
    if (s.en[0] && s.a0 != 0) w[s.a0] = ref_op(w[s.a0], s.op0, s.d0);
    if (s.en[1] && s.a1 != 0) w[s.a1] = ref_op(w[s.a1], s.op1, s.d1);
    hit = -1;
    foreach (live_q[i]) if (live_q[i].id == int'(s.rid)) hit = i;
    if (s.rs) nv = (hit >= 0) ? live_q[hit].bits : m_regs;
    else      nv = w;
    e.rd    = {nv[s.r2], nv[s.r1], nv[s.r0]};
    e.ready = live_q.size() < DEPTH;
    e.id    = CB'(m_tail);
    e.count = (CB+1)'(live_q.size());
    e.err   = m_err;
    exp_q.push_back(e);
    if (s.rst) begin
      m_regs = 8'h01;
      live_q.delete();
      m_tail = 0;
      m_err = 1'b0;
    end else if (s.rs) begin
      m_err = (hit < 0);
      if (hit >= 0) begin
        m_regs = nv;
        while (live_q.size() > hit + 1) void'(live_q.pop_back());
        m_tail = (int'(s.rid) + 1) % DEPTH;
      end
    end else begin
      m_regs = w;
      rel_ok = s.rl && live_q.size() > 0;
      take_ok = s.tk && (live_q.size() < DEPTH || rel_ok);
      bad = (s.tk && !take_ok) || (s.rl && !rel_ok);
      m_err = bad;
      if (!bad) begin
        if (rel_ok) void'(live_q.pop_front());
        if (take_ok) begin
          live_q.push_back('{id: m_tail, bits: w});
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rd_data", 8'(rd_data), 8'(e.rd));
      chk("ckpt_ready", 8'(ckpt_ready), 8'(e.ready));
      chk("ckpt_id", 8'(ckpt_id), 8'(e.id));
      chk("ckpt_count", 8'(ckpt_count), 8'(e.count));
      chk("ckpt_err", 8'(ckpt_err), 8'(e.err));
    end
  end

  initial begin
    stim_t s;
    int wait_cnt;
    m_regs = 8'h01;
    m_tail = 0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    // reset state over all registers
    step(idle(0, 1, 2));
    step(idle(3, 4, 5));
    step(idle(6, 7, 0));
    // chained same-address write: SET 1 then AND 0
    s = idle(3, 3, 0);
    s.en = 2'b11; s.a0 = 3; s.a1 = 3;
    s.op0 = 2'd0; s.d0 = 1; s.op1 = 2'd1; s.d1 = 0;
    step(s);
    step(idle(3, 0, 1));
    step(wr1(3, 0, 1'b1, 3, 3, 3));
    step(wr1(0, 0, 1'b0, 0, 3, 0));
    step(idle(0, 3, 2));
    // fill the buffer
    s = wr1(2, 0, 1'b1, 2, 3, 0); s.tk = 1; step(s);
    s = wr1(2, 0, 1'b0, 2, 3, 0); s.tk = 1; step(s);
    s = idle(2, 3, 0); s.tk = 1; step(s);
    step(s);
    step(s);
    s = idle(2, 3, 0); s.tk = 1; s.rl = 1; step(s);
    step(idle());
    step(idle());
    // restore with same-cycle write discarded
    s = idle(); s.rst = 1; step(s);
    s = wr1(2, 0, 1'b1); s.tk = 1; step(s);
    s = wr1(4, 0, 1'b1); s.tk = 1; step(s);
    s = wr1(6, 0, 1'b1); s.tk = 1; step(s);
    s = wr1(5, 0, 1'b1, 5, 4, 6); s.rs = 1; s.rid = 1; step(s);
    step(idle(5, 4, 6));
    step(idle(2, 6, 5));
    // illegal requests
    s = wr1(7, 0, 1'b1, 7, 5, 4); s.rs = 1; s.rid = 3; step(s);
    step(idle(7, 5, 4));
    s = idle(); s.rl = 1; step(s);
    step(s);
    step(s);
    s = idle(); s.rs = 1; s.rid = 0; step(s);
    step(idle());
    // three laps of take/release
    for (int i = 0; i < 12; i++) begin
      s = wr1(1 + (i % 7), $urandom_range(0, 3), 1'($urandom));
      s.tk = 1;
      step(s);
      s = idle($urandom_range(0, 7), $urandom_range(0, 7), 1);
      s.rl = 1;
      step(s);
    end
    for (int i = 0; i < 3; i++) begin
      s = wr1(1 + i, 2'd3, 1'b1, 1, 2, 3);
      s.tk = 1;
      step(s);
    end
    s = wr1(7, 0, 1'b1, 1, 2, 3); s.rs = 1;
    s.rid = 2'(live_q[0].id);
    step(s);
    step(idle(1, 2, 3));
    s = idle(); s.tk = 1; step(s); step(s);
    step(idle(4, 5, 6));
    s = idle(); s.rst = 1; step(s);
    step(idle(1, 2, 3));
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      s.rst = ($urandom_range(0, 99) == 0);
      s.en  = 2'($urandom);
      s.a0  = 3'($urandom);
      s.a1  = ($urandom_range(0, 3) == 0) ? s.a0 : 3'($urandom);
      s.op0 = 2'($urandom);
      s.op1 = 2'($urandom);
      s.d0  = 1'($urandom);
      s.d1  = 1'($urandom);
      s.tk  = ($urandom_range(0, 9) < 4);
      s.rl  = ($urandom_range(0, 9) < 3);
      s.rs  = ($urandom_range(0, 11) == 0);
      s.rid = 2'($urandom);
      s.r0  = 3'($urandom);
      s.r1  = 3'($urandom);
      s.r2  = 3'($urandom);
      step(s);
    end
    @(posedge clk);
    #1;
    s = idle();
    reset = 1'b0;
    ckpt_take = 0; ckpt_release = 0; ckpt_restore = 0; wr_en = 0;
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/predicate_regfile_ckpt.md
# predicate_regfile_ckpt

Parametrised predicate register file with two combining write ports, N combinational read ports and a circular checkpoint buffer for branch speculation. It sits in decode/issue. Issue reads guard predicates from it, and compare units write it. The branch unit takes snapshots at predicted branches, releases them in order when a branch resolves correctly, and restores one on a mispredict. Predicate p0 is hardwired true.

## Interface
Parameters:
- REG_BITS, 3, log2 of register count; NUM_REG = 1<<REG_BITS.
- NUM_RD, 3, number of read ports.
- CKPT_BITS, 2, log2 of checkpoint depth; CKPT_DEPTH = 1<<CKPT_BITS.
- BYPASS, 1, 1 = a read of a register written this cycle returns the post-write value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- rd_addr  in  NUM_RD*REG_BITS  packed read addresses; port k is bits [k*REG_BITS +: REG_BITS].
- rd_data  out  NUM_RD  read data; bit k belongs to port k.
- wr_en  in  2  write enables, one per write port.
- wr_addr  in  2*REG_BITS  packed write addresses.
- wr_op  in  4  packed 2-bit ops: SET, AND, OR, XOR.
- wr_data  in  2  operand bits.
- ckpt_take  in  1  request a snapshot.
- ckpt_ready  out  1  buffer not full; a take is accepted only when this is high.
- ckpt_id  out  CKPT_BITS  ID that the next accepted take will receive (the tail pointer).
- ckpt_release  in  1  free the oldest checkpoint.
- ckpt_restore  in  1  restore a checkpoint.
- ckpt_restore_id  in  CKPT_BITS  ID of the checkpoint to restore.
- ckpt_count  out  CKPT_BITS+1  number of live checkpoints.
- ckpt_err  out  1  one-cycle pulse on an illegal request.

## Operation
Register writes:
- The new value is old OP wr_data: SET gives d, AND gives old&d, OR gives old|d, XOR gives old^d.
- Writes to p0 are dropped. p0 always reads 1.
- When both ports write the same address, port 1 operates on the result of port 0. This chaining lets compare pairs combine in a single cycle.

Reads:
- Reads are combinational from the array.
- With BYPASS=1, the read returns the value the register will hold after this edge, including restore effects.

Checkpoint buffer:
- Circular buffer of CKPT_DEPTH snapshots, each NUM_REG bits, managed by head (oldest), tail (next free) and count.
- Take, accepted when ckpt_ready is high:
  - Stores the register state after this cycle's writes into slot tail.
  - Then tail is incremented and count is incremented.
- Release, accepted when count > 0: head is incremented and count is decremented.
- Restore:
  - The request is legal when ckpt_restore_id lies within [head, head+count) modulo depth.
  - The whole array is loaded from that slot. Same-cycle register writes are discarded.
  - tail becomes id+1 and count becomes (id-head mod depth)+1, keeping the restored checkpoint live.
  - All younger checkpoints are discarded.
- Priority:
  - Restore overrides take and release in the same cycle; those requests are ignored and do not raise an error.
  - Take and release in the same cycle are both applied, even when full, so count is unchanged.

Error cases. Each pulses ckpt_err for one cycle with no state change:
- take when ckpt_ready is low, with no release in the same cycle;
- release with count == 0;
- restore to an ID that is not live.

Reset values:
- p0=1, all other registers 0.
- head=tail=0, count=0.
- ckpt_ready=1, ckpt_id=0, ckpt_err=0.
- Snapshot contents are don't-care.

## Timing
- Write latency: visible on rd_data the next cycle, or the same cycle with BYPASS=1.
- Restore latency: the restored values appear after the edge; with BYPASS=1, rd_data shows them in the request cycle.
- ckpt_ready, ckpt_id and ckpt_count are registered-state outputs that update one edge after the event.
- ckpt_err is registered and asserted in the cycle after the offending request.
- Reset asserted mid-speculation clears all checkpoints at the edge; any request made in that cycle is ignored.

## Structure
- The shared package predicate_pkg holds:
  - the op encodings PRED_SET=2'b00, PRED_AND=2'b01, PRED_OR=2'b10, PRED_XOR=2'b11;
  - the pred_combine function.
- Sub-module predicate_ckpt_buffer holds the snapshot storage, head/tail/count, the legality checks and ckpt_err. It receives the next-state register vector from the top level and returns the restore vector.
- The top level holds the register array, the write combine chain, bypass muxing and the read ports.

## Test plan
- Reset, then read all ports: p0=1, all others 0, ckpt_count=0, ckpt_ready=1.
- Same cycle: port 0 SET p3=1 and port 1 AND p3=0 → p3=0. Then write p0 SET 0 → p0 still reads 1. With BYPASS=1, a same-cycle read of p3 returns the new value.
- Filling the buffer:
  - Stimulus: set p2=1, take (id 0); set p2=0, take (id 1); take ×2.
  - Required: count=4, ready=0. A fifth take gives ckpt_err and count stays 4. Take plus release in the same cycle gives count=4 and head=1.
- Restoring:
  - Stimulus: three takes (ids 0, 1, 2) with distinct states, restore id 1, plus a same-cycle write p5=1.
  - Required: registers equal snapshot 1, p5 reflects the snapshot rather than the write, count=2, ckpt_id=2.
- Restore of a non-live ID (already released, or ≥ tail) → ckpt_err, registers unchanged. Release with count=0 → ckpt_err.
- Wrap-around: twelve take/release pairs (three laps) followed by a restore of the oldest live ID → correct contents. Reset asserted with count=3 → count=0 next cycle.
